stream_arb_2_1: RTL and testbench
=================================

Name: stream_arb_2_1

Overview:
Two-input, packet-aware, round-robin stream arbiter that merges streams A and B into one registered valid/ready output stream. Sits directly upstream of the datapath consumer. It generates the 2:1 select itself and steers data through per-bit mux_2_1 instances, where s=1 selects input a. Arbitration decisions are made only at packet boundaries.

Parameters:
WIDTH, 8, data width of a_data, b_data and y_data.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
a_data  input  WIDTH  stream A payload
a_last  input  1  stream A end-of-packet marker, qualified by a_valid
a_valid  input  1  stream A beat valid
a_ready  output  1  stream A beat accepted this cycle
b_data  input  WIDTH  stream B payload
b_last  input  1  stream B end-of-packet marker
b_valid  input  1  stream B beat valid
b_ready  output  1  stream B beat accepted this cycle
y_data  output  WIDTH  registered merged payload
y_last  output  1  registered end-of-packet marker
y_src  output  1  source of the current y beat: 1 = A, 0 = B
y_valid  output  1  output beat valid
y_ready  input  1  downstream accepts the y beat

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low, rst_n. Asserting rst_n=0 immediately forces:
  - y_valid=0, y_data=0, y_last=0, y_src=0
  - state=IDLE, last_winner=B
- Reset mid-packet drops the in-flight beat and any partial packet. After reset, A wins the first tie.
- load = !y_valid || y_ready. The output register captures a beat only when load=1.
- Handshake rules:
  - A transfer occurs when x_valid && x_ready.
  - a_ready and b_ready are combinational from state, valids, last_winner and load.
  - a_ready and b_ready are never both 1 in the same cycle.
  - Input valids must hold until accepted. y_valid stays asserted, with y_data/y_last/y_src stable, until y_ready.
- Grant (combinational), with sel=1 meaning A:
  - IDLE, only a_valid: grant A.
  - IDLE, only b_valid: grant B.
  - IDLE, both valid: grant the side opposite last_winner.
  - LOCK_A: grant A only, even if b_valid=1.
  - LOCK_B: grant B only, even if a_valid=1.
  - a_ready = load && grant_A && a_valid; b_ready likewise for B.
- Capture on transfer: y_data = mux(sel, a_data, b_data); y_last = selected last; y_src = sel; y_valid = 1.
- If load=1 and no transfer occurs: y_valid goes to 0.
- State transitions, evaluated on transfer only:
  - IDLE + A beat, a_last=0 -> LOCK_A.
  - IDLE + A beat, a_last=1 -> IDLE, last_winner=A.
  - IDLE + B beat: symmetric (LOCK_B, or IDLE with last_winner=B).
  - LOCK_A + A beat with a_last=1 -> IDLE, last_winner=A. LOCK_B is symmetric.
  - No transfer: state holds. A locked side going a_valid=0 mid-packet keeps the lock.
- Latency: 1 cycle from input transfer to y_valid.
- Throughput: 1 beat/cycle sustained while y_ready=1. Back-to-back transfers are allowed with y_valid held high.
- Simultaneous events: output drain (y_ready) and a new capture in the same cycle are legal; the register is overwritten.
- Single-beat packets (last=1) never leave IDLE. Two competing streams of such packets alternate A,B,A,B.
- Illegal encoding: an unreachable state value returns to IDLE on the next clock.

Decomposition:
- Shared package arb_pkg:
  - state encoding IDLE=2'd0, LOCK_A=2'd1, LOCK_B=2'd2
  - constants SRC_A=1'b1, SRC_B=1'b0
- Sub-module: a generate loop of WIDTH mux_2_1 instances for the data path, plus one for last, all driven by sel.
- The FSM, grant logic and output register stay in stream_arb_2_1.

Test Plan:
- Reset: assert rst_n=0 mid-packet with y_valid=1 -> y_valid/y_data/y_last/y_src go to 0 without a clock edge. After release, tie A/B -> A granted first.
- Single-beat tie: A=0x11, 0x22 and B=0x33, 0x44, all last=1, both valid, y_ready=1 -> y sequence 0x11(A), 0x33(B), 0x22(A), 0x44(B), one beat per cycle.
- Packet lock: A sends a 3-beat packet 0xA0,0xA1,0xA2 (last on 0xA2) while B holds 0xB0 valid -> b_ready=0 throughout. Output 0xA0,0xA1,0xA2,0xB0.
- Backpressure: y_ready=0 for 4 cycles with y holding 0x55 -> y stable, a_ready=b_ready=0. When y_ready returns to 1, the next beat captures in the same cycle.
- Lock gap: LOCK_B with b_valid dropping 3 cycles mid-packet and a_valid=1 -> no A beat accepted until the B beat with b_last=1 transfers.
- Idle: no valids -> y_valid=0 after the last drain, state stays IDLE.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared encodings for the packet-aware 2:1 stream arbiter.
package arb_pkg;

    // Arbiter FSM: IDLE may re-arbitrate; LOCK_x holds the grant until x's last beat.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } arb_state_t;

    // Source encoding used for sel, y_src and last_winner.
    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;

endpackage

// File: rtl/mux_2_1.sv
// Single-bit 2:1 multiplexer; s=1 selects a.
module mux_2_1 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? a : b;

endmodule

// File: rtl/stream_arb_2_1_mux.sv
// Beat steering: one mux_2_1 per data bit plus one for the last marker, all on sel.
module stream_arb_2_1_mux #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    input  logic             sel,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_data_mux
        mux_2_1 u_mux (
            .a (a_data[i]),
            .b (b_data[i]),
            .s (sel),
            .y (y_data[i])
        );
    end

    mux_2_1 u_last_mux (
        .a (a_last),
        .b (b_last),
        .s (sel),
        .y (y_last)
    );

endmodule

// File: rtl/stream_arb_2_1.sv
// Two-input packet-aware round-robin stream arbiter with a registered output stage.
//
// Handshake: every stream (a, b, y) uses valid/ready. A beat moves when valid && ready
// in the same cycle; valid must not drop and payload must not change until that happens.
// The output register reloads whenever it is empty or being drained (load).
module stream_arb_2_1
    import arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    output logic             y_src,
    output logic             y_valid,
    input  logic             y_ready
);

    arb_state_t       state;
    logic             last_winner;
    logic             load;
    logic             grant_a;
    logic             grant_b;
    logic             sel;
    logic             xfer;
    logic [WIDTH-1:0] mux_data;
    logic             mux_last;

    assign load = !y_valid || y_ready;

    // Grant: re-arbitrate only in IDLE; a locked side keeps the grant even while idle.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    grant_a = (last_winner == SRC_B);
                    grant_b = (last_winner == SRC_A);
                end else begin
                    grant_a = a_valid;
                    grant_b = b_valid;
                end
            end
            LOCK_A:  grant_a = 1'b1;
            LOCK_B:  grant_b = 1'b1;
            default: begin
                grant_a = 1'b0;
                grant_b = 1'b0;
            end
        endcase
    end

    assign a_ready = load && grant_a && a_valid;
    assign b_ready = load && grant_b && b_valid;
    assign xfer    = a_ready || b_ready;
    assign sel     = grant_a ? SRC_A : SRC_B;

    stream_arb_2_1_mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a_data (a_data),
        .a_last (a_last),
        .b_data (b_data),
        .b_last (b_last),
        .sel    (sel),
        .y_data (mux_data),
        .y_last (mux_last)
    );

    // Output register: capture the granted beat on transfer, empty on a load with no transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_last  <= 1'b0;
            y_src   <= SRC_B;
        end else if (load) begin
            if (xfer) begin
                y_valid <= 1'b1;
                y_data  <= mux_data;
                y_last  <= mux_last;
                y_src   <= sel;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

    // Packet FSM: advances only on accepted beats; last_winner updates when a packet closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_winner <= SRC_B;
        end else begin
            case (state)
                IDLE: begin
                    if (a_ready) begin
                        if (a_last) begin
                            last_winner <= SRC_A;
                        end else begin
                            state <= LOCK_A;
                        end
                    end else if (b_ready) begin
                        if (b_last) begin
                            last_winner <= SRC_B;
                        end else begin
                            state <= LOCK_B;
                        end
                    end
                end
                LOCK_A: begin
                    if (a_ready && a_last) begin
                        state       <= IDLE;
                        last_winner <= SRC_A;
                    end
                end
                LOCK_B: begin
                    if (b_ready && b_last) begin
                        state       <= IDLE;
                        last_winner <= SRC_B;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_arb_2_1.sv
// Directed bench for stream_arb_2_1: tie alternation, packet lock, backpressure,
// lock gap, idle drain and asynchronous reset mid-packet.
module tb_stream_arb_2_1;
    import arb_pkg::*;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a_data;
    logic             a_last;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_last;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] y_data;
    logic             y_last;
    logic             y_src;
    logic             y_valid;
    logic             y_ready;

    int vectors;
    int miscompares;

    stream_arb_2_1 #(
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_data  (a_data),
        .a_last  (a_last),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_last  (b_last),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .y_data  (y_data),
        .y_last  (y_last),
        .y_src   (y_src),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Full output beat check
    task automatic chk_y(input string tag, input logic [7:0] d, input logic l, input logic s);
        chk1({tag, ".y_valid"}, y_valid, 1'b1);
        chk8({tag, ".y_data"}, y_data, d);
        chk1({tag, ".y_last"}, y_last, l);
        chk1({tag, ".y_src"}, y_src, s);
    endtask

    task automatic chk_rdy(input string tag, input logic ea, input logic eb);
        chk1({tag, ".a_ready"}, a_ready, ea);
        chk1({tag, ".b_ready"}, b_ready, eb);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [7:0] d, input logic l);
        a_valid = v;
        a_data  = d;
        a_last  = l;
    endtask

    task automatic set_b(input logic v, input logic [7:0] d, input logic l);
        b_valid = v;
        b_data  = d;
        b_last  = l;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        y_ready = 1'b0;
        set_a(1'b0, 8'h00, 1'b0);
        set_b(1'b0, 8'h00, 1'b0);

        // Reset state
        tick();
        tick();
        chk1("rst.y_valid", y_valid, 1'b0);
        chk8("rst.y_data", y_data, 8'h00);
        chk1("rst.y_last", y_last, 1'b0);
        chk1("rst.y_src", y_src, 1'b0);
        chk8("rst.state", {6'b0, dut.state}, 8'h00);
        rst_n = 1'b1;

        // Single-beat tie: A wins first after reset, then strict alternation
        y_ready = 1'b1;
        set_a(1'b1, 8'h11, 1'b1);
        set_b(1'b1, 8'h33, 1'b1);
        #1;
        chk_rdy("tie0", 1'b1, 1'b0);
        tick();
        chk_y("tie0", 8'h11, 1'b1, SRC_A);
        set_a(1'b1, 8'h22, 1'b1);
        #1;
        chk_rdy("tie1", 1'b0, 1'b1);
        tick();
        chk_y("tie1", 8'h33, 1'b1, SRC_B);
        set_b(1'b1, 8'h44, 1'b1);
        #1;
        chk_rdy("tie2", 1'b1, 1'b0);
        tick();
        chk_y("tie2", 8'h22, 1'b1, SRC_A);
        set_a(1'b0, 8'h00, 1'b0);
        #1;
        chk_rdy("tie3", 1'b0, 1'b1);
        tick();
        chk_y("tie3", 8'h44, 1'b1, SRC_B);
        set_b(1'b0, 8'h00, 1'b0);

        // Idle drain: no valids, output empties, FSM stays IDLE
        tick();
        chk1("idle0.y_valid", y_valid, 1'b0);
        chk8("idle0.state", {6'b0, dut.state}, 8'h00);
        tick();
        chk1("idle1.y_valid", y_valid, 1'b0);
        chk8("idle1.state", {6'b0, dut.state}, 8'h00);

        // Packet lock: 3-beat A packet holds off a waiting B beat
        set_a(1'b1, 8'hA0, 1'b0);
        set_b(1'b1, 8'hB0, 1'b1);
        #1;
        chk_rdy("lock0", 1'b1, 1'b0);
        tick();
        chk_y("lock0", 8'hA0, 1'b0, SRC_A);
        chk8("lock0.state", {6'b0, dut.state}, 8'h01);
        set_a(1'b1, 8'hA1, 1'b0);
        #1;
        chk_rdy("lock1", 1'b1, 1'b0);
        tick();
        chk_y("lock1", 8'hA1, 1'b0, SRC_A);
        set_a(1'b1, 8'hA2, 1'b1);
        #1;
        chk_rdy("lock2", 1'b1, 1'b0);
        tick();
        chk_y("lock2", 8'hA2, 1'b1, SRC_A);
        set_a(1'b0, 8'h00, 1'b0);
        #1;
        chk_rdy("lock3", 1'b0, 1'b1);
        tick();
        chk_y("lock3", 8'hB0, 1'b1, SRC_B);
        set_b(1'b0, 8'h00, 1'b0);

        // Backpressure: y holds 0x55 while y_ready=0, both inputs wait
        set_a(1'b1, 8'h55, 1'b1);
        tick();
        chk_y("bp_load", 8'h55, 1'b1, SRC_A);
        set_a(1'b1, 8'h66, 1'b1);
        set_b(1'b1, 8'h77, 1'b1);
        y_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_rdy($sformatf("bp_hold%0d", i), 1'b0, 1'b0);
            tick();
            chk_y($sformatf("bp_hold%0d", i), 8'h55, 1'b1, SRC_A);
        end
        // Drain and capture in the same cycle; B wins since A took the last packet
        y_ready = 1'b1;
        #1;
        chk_rdy("bp_rel", 1'b0, 1'b1);
        tick();
        chk_y("bp_rel", 8'h77, 1'b1, SRC_B);
        set_b(1'b0, 8'h00, 1'b0);
        #1;
        chk_rdy("bp_a", 1'b1, 1'b0);
        tick();
        chk_y("bp_a", 8'h66, 1'b1, SRC_A);
        set_a(1'b0, 8'h00, 1'b0);

        // Lock gap: B locked, b_valid drops for 3 cycles, A must wait
        set_b(1'b1, 8'hC0, 1'b0);
        tick();
        chk_y("gap0", 8'hC0, 1'b0, SRC_B);
        chk8("gap0.state", {6'b0, dut.state}, 8'h02);
        set_b(1'b0, 8'h00, 1'b0);
        set_a(1'b1, 8'hD0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_rdy($sformatf("gap_wait%0d", i), 1'b0, 1'b0);
            tick();
            chk1($sformatf("gap_wait%0d.y_valid", i), y_valid, 1'b0);
        end
        set_b(1'b1, 8'hC1, 1'b1);
        #1;
        chk_rdy("gap_end", 1'b0, 1'b1);
        tick();
        chk_y("gap_end", 8'hC1, 1'b1, SRC_B);
        set_b(1'b0, 8'h00, 1'b0);
        #1;
        chk_rdy("gap_a", 1'b1, 1'b0);
        tick();
        chk_y("gap_a", 8'hD0, 1'b1, SRC_A);
        set_a(1'b0, 8'h00, 1'b0);
        tick();
        chk1("gap_drain.y_valid", y_valid, 1'b0);

        // Asynchronous reset mid-packet clears the output without a clock edge
        set_a(1'b1, 8'hE0, 1'b0);
        tick();
        chk_y("mid_pkt", 8'hE0, 1'b0, SRC_A);
        y_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk1("arst.y_valid", y_valid, 1'b0);
        chk8("arst.y_data", y_data, 8'h00);
        chk1("arst.y_last", y_last, 1'b0);
        chk1("arst.y_src", y_src, 1'b0);
        chk8("arst.state", {6'b0, dut.state}, 8'h00);
        set_a(1'b0, 8'h00, 1'b0);
        tick();
        rst_n = 1'b1;

        // After reset the partial A packet is gone and A wins the first tie
        y_ready = 1'b1;
        set_a(1'b1, 8'hF0, 1'b1);
        set_b(1'b1, 8'hF1, 1'b1);
        #1;
        chk_rdy("post_rst0", 1'b1, 1'b0);
        tick();
        chk_y("post_rst0", 8'hF0, 1'b1, SRC_A);
        set_a(1'b0, 8'h00, 1'b0);
        #1;
        chk_rdy("post_rst1", 1'b0, 1'b1);
        tick();
        chk_y("post_rst1", 8'hF1, 1'b1, SRC_B);
        set_b(1'b0, 8'h00, 1'b0);
        tick();
        chk1("final.y_valid", y_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
